hamming_serial_rx: RTL and testbench

HAMMING_SERIAL_RX -- requirements
Module: hamming_serial_rx

---
 rtl/hamming_serial_rx_pkg.sv | 32 +++
 rtl/hamming74_correct.sv | 41 ++++
 rtl/hamming_serial_rx.sv | 151 +++++++++++++++
 tb/tb_hamming_serial_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_serial_rx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | hamming_serial_rx_pkg                                                |
// | Shared Hamming(7,4) constants and receiver FSM state encoding.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hamming_serial_rx_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int POS_W  = 3;

  // Codeword index of each parity bit (position = index + 1).
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int P4_IDX = 3;

  localparam int D0_IDX = 2;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage : hamming_serial_rx_pkg
`default_nettype wire

// File: rtl/hamming74_correct.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | hamming74_correct                                                    |
// | Combinational Hamming(7,4) syndrome, single-bit correction, extract. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hamming74_correct
  import hamming_serial_rx_pkg::*;
(
  input  logic [CW_W-1:0]   cw_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic [POS_W-1:0]  pos_o
);

  logic [POS_W-1:0] syn;
  logic [CW_W-1:0]  flip_mask;
  logic [CW_W-1:0]  fixed_cw;

  always_comb begin
    syn[0] = cw_i[P1_IDX] ^ cw_i[D0_IDX] ^ cw_i[D1_IDX] ^ cw_i[D3_IDX];
    syn[1] = cw_i[P2_IDX] ^ cw_i[D0_IDX] ^ cw_i[D2_IDX] ^ cw_i[D3_IDX];
    syn[2] = cw_i[P4_IDX] ^ cw_i[D1_IDX] ^ cw_i[D2_IDX] ^ cw_i[D3_IDX];
  end

  // Syndrome value is the 1-based position of the bad bit; zero flips nothing.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < CW_W; i++) begin
      flip_mask[i] = (syn == POS_W'(i + 1));
    end
  end

  assign fixed_cw = cw_i ^ flip_mask;
  assign data_o   = {fixed_cw[D3_IDX], fixed_cw[D2_IDX], fixed_cw[D1_IDX], fixed_cw[D0_IDX]};
  assign err_o    = (syn != '0);
  assign pos_o    = syn;

endmodule : hamming74_correct
`default_nettype wire

// File: rtl/hamming_serial_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | hamming_serial_rx                                                    |
// | Serial LSB-first Hamming(7,4) receiver with correction and counters. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hamming_serial_rx
  import hamming_serial_rx_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ABT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              sin_sof,
  output logic              sin_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              err_flag,
  output logic [POS_W-1:0]  err_pos,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [ABT_W-1:0]  abort_cnt,
  input  logic              cnt_clr
);

  state_e              state_q;
  logic [2:0]          bit_cnt_q;
  logic [CW_W-1:0]     cw_q;
  logic [DATA_W-1:0]   dout_q;
  logic                dout_valid_q;
  logic                err_flag_q;
  logic [POS_W-1:0]    err_pos_q;
  logic [CNT_W-1:0]    corr_cnt_q;
  logic [CNT_W-1:0]    corr_cnt_d;
  logic [ABT_W-1:0]    abort_cnt_q;
  logic [ABT_W-1:0]    abort_cnt_d;

  logic                accept;
  logic                abort_evt;
  logic                corr_evt;
  logic [DATA_W-1:0]   dec_data;
  logic                dec_err;
  logic [POS_W-1:0]    dec_pos;

  hamming74_correct u_correct (
    .cw_i   (cw_q),
    .data_o (dec_data),
    .err_o  (dec_err),
    .pos_o  (dec_pos)
  );

  assign sin_ready = (state_q == ST_IDLE) || (state_q == ST_SHIFT);
  assign accept    = sin_valid && sin_ready;
  assign abort_evt = (state_q == ST_SHIFT) && accept && sin_sof;
  assign corr_evt  = (state_q == ST_DECODE) && dec_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      cw_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_flag_q   <= 1'b0;
      err_pos_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && sin_sof) begin
            cw_q      <= {{(CW_W-1){1'b0}}, sin};
            bit_cnt_q <= 3'd1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (accept) begin
            if (sin_sof) begin
              cw_q      <= {{(CW_W-1){1'b0}}, sin};
              bit_cnt_q <= 3'd1;
            end else begin
              cw_q[bit_cnt_q] <= sin;
              bit_cnt_q       <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'(CW_W - 1)) begin
                state_q <= ST_DECODE;
              end
            end
          end
        end
        ST_DECODE: begin
          dout_q       <= dec_data;
          err_flag_q   <= dec_err;
          err_pos_q    <= dec_pos;
          dout_valid_q <= 1'b1;
          bit_cnt_q    <= '0;
          state_q      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d = '0;
    end else if (corr_evt && (corr_cnt_q != '1)) begin
      corr_cnt_d = corr_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (cnt_clr) begin
      abort_cnt_d = '0;
    end else if (abort_evt && (abort_cnt_q != '1)) begin
      abort_cnt_d = abort_cnt_q + ABT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      corr_cnt_q  <= corr_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign err_flag   = err_flag_q;
  assign err_pos    = err_pos_q;
  assign corr_cnt   = corr_cnt_q;
  assign abort_cnt  = abort_cnt_q;

endmodule : hamming_serial_rx
`default_nettype wire

// File: tb/tb_hamming_serial_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_hamming_serial_rx                                                 |
// | Scoreboard bench: directed codewords with hand-computed results.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hamming_serial_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_sof = 1'b0;
  logic       dout_ready = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       sin_ready;
  logic [3:0] dout;
  logic       dout_valid;
  logic       err_flag;
  logic [2:0] err_pos;
  logic [15:0] corr_cnt;
  logic [7:0] abort_cnt;

  logic       sin_ready_s;
  logic [3:0] dout_s;
  logic       dout_valid_s;
  logic       err_flag_s;
  logic [2:0] err_pos_s;
  logic [1:0] corr_cnt_s;
  logic [7:0] abort_cnt_s;

  hamming_serial_rx #(.CNT_W(16), .ABT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof),
    .sin_ready(sin_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err_flag(err_flag), .err_pos(err_pos), .corr_cnt(corr_cnt), .abort_cnt(abort_cnt),
    .cnt_clr(cnt_clr)
  );

  hamming_serial_rx #(.CNT_W(2), .ABT_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof),
    .sin_ready(sin_ready_s), .dout(dout_s), .dout_valid(dout_valid_s), .dout_ready(dout_ready),
    .err_flag(err_flag_s), .err_pos(err_pos_s), .corr_cnt(corr_cnt_s), .abort_cnt(abort_cnt_s),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       f;
    logic [2:0] p;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass = 0;
  int          n_checks = 0;
  logic [15:0] exp_corr = '0;
  logic [7:0]  exp_abt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  task automatic expect_frame(input logic [3:0] d, input logic f, input logic [2:0] p, input bit count_it);
    sb_q.push_back('{d: d, f: f, p: p});
    if (f && count_it) exp_corr = exp_corr + 16'd1;
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic send_bit(input logic b, input logic sof);
    int guard = 0;
    sin = b; sin_sof = sof; sin_valid = 1'b1;
    while (!sin_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!sin_ready) bound_fail("sin_ready_wait");
    @(posedge clk); #1;
    sin_valid = 1'b0; sin_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] cw, input int gap_after);
    for (int i = 0; i < 7; i++) begin
      send_bit(cw[i], (i == 0));
      if (i == gap_after) begin
        repeat (2) begin @(posedge clk); #1; end
      end
    end
    check("decode_sin_ready", {31'd0, sin_ready}, 32'd0);
    check("decode_dout_valid", {31'd0, dout_valid}, 32'd0);
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 60) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb_q.size() != 0) begin
      bound_fail("frame_output_wait");
      sb_q.delete();
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame: actual=dout_valid required=no_output");
      end else begin
        e = sb_q.pop_front();
        check("dout", {28'd0, dout}, {28'd0, e.d});
        check("err_flag", {31'd0, err_flag}, {31'd0, e.f});
        check("err_pos", {29'd0, err_pos}, {29'd0, e.p});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    check("rst_sin_ready", {31'd0, sin_ready}, 32'd1);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_dout", {28'd0, dout}, 32'd0);
    check("rst_err", {28'd0, err_flag, err_pos}, 32'd0);
    check("rst_cnts", {8'd0, corr_cnt, abort_cnt}, 32'd0);
    check("rst_sat_valid", {31'd0, dout_valid_s}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bits without sof in IDLE are ignored.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    expect_frame(4'b1011, 1'b0, 3'd0, 1'b1);
    send_frame(7'b1010101, -1);
    drain();
    check("corr_cnt_clean", {16'd0, corr_cnt}, {16'd0, exp_corr});

    expect_frame(4'b1011, 1'b1, 3'd3, 1'b1);
    send_frame(7'b1010001, -1);
    drain();
    check("corr_cnt_1", {16'd0, corr_cnt}, {16'd0, exp_corr});

    expect_frame(4'b0110, 1'b1, 3'd1, 1'b1);
    send_frame(7'b0110010, 3);
    expect_frame(4'b1011, 1'b1, 3'd6, 1'b1);
    send_frame(7'b1110101, -1);
    expect_frame(4'b1011, 1'b1, 3'd7, 1'b1);
    send_frame(7'b0010101, -1);
    drain();
    check("corr_cnt_4", {16'd0, corr_cnt}, {16'd0, exp_corr});
    check("sat_corr_cnt", {30'd0, corr_cnt_s}, 32'd3);

    // Output held while the consumer stalls.
    dout_ready = 1'b0;
    expect_frame(4'b0110, 1'b0, 3'd0, 1'b1);
    send_frame(7'b0110011, -1);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("hold_dout", {28'd0, dout}, 32'b0110);
      check("hold_valid_ready", {30'd0, dout_valid, sin_ready}, 32'b10);
      @(posedge clk); #1;
    end
    dout_ready = 1'b1;
    drain();

    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    exp_abt = exp_abt + 8'd1;
    expect_frame(4'b1011, 1'b0, 3'd0, 1'b1);
    send_frame(7'b1010101, -1);
    drain();
    check("abort_cnt_1", {24'd0, abort_cnt}, {24'd0, exp_abt});

    expect_frame(4'b1011, 1'b1, 3'd3, 1'b1);
    send_frame(7'b1010001, -1);
    drain();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_corr = '0; exp_abt = '0;
    check("clr_corr", {16'd0, corr_cnt}, {16'd0, exp_corr});
    check("clr_abort", {24'd0, abort_cnt}, {24'd0, exp_abt});
    check("clr_sat_corr", {30'd0, corr_cnt_s}, 32'd0);

    // Clear held across the DECODE edge of an erroneous frame.
    cnt_clr = 1'b1;
    expect_frame(4'b1011, 1'b1, 3'd3, 1'b0);
    send_frame(7'b1010001, -1);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    drain();
    check("clr_priority", {16'd0, corr_cnt}, 32'd0);

    send_bit(1'b1, 1'b1);
    exp_abt = exp_abt + 8'd1;
    expect_frame(4'b1011, 1'b1, 3'd3, 1'b1);
    send_frame(7'b1010001, -1);
    drain();
    check("pre_rst_cnts", {8'd0, corr_cnt, abort_cnt}, {8'd0, exp_corr, exp_abt});

    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {23'd0, dout_valid, dout, err_flag, err_pos}, 32'd0);
    check("async_rst_cnts", {8'd0, corr_cnt, abort_cnt}, 32'd0);
    check("async_rst_ready", {31'd0, sin_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_corr = '0; exp_abt = '0;
    @(posedge clk); #1;
    expect_frame(4'b0110, 1'b0, 3'd0, 1'b1);
    send_frame(7'b0110011, -1);
    drain();
    check("post_rst_cnts", {8'd0, corr_cnt, abort_cnt}, {8'd0, exp_corr, exp_abt});

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hamming_serial_rx
`default_nettype wire
